// File: rtl/cas_key_loader_if.sv
// Handshake and key bus between the secure key store / controller and the CAS key loader.
// The master drives the load/serial inputs; the loader (slave) returns status and the committed key.
interface cas_key_loader_if #(
    parameter int KEY_W = 64
);
    logic             load_start;
    logic             clear;
    logic             ser_valid;
    logic             ser_data;
    logic             ser_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             busy;
    logic             err;

    modport master (
        output load_start, clear, ser_valid, ser_data,
        input  ser_ready, key_out, key_valid, busy, err
    );

    modport slave (
        input  load_start, clear, ser_valid, ser_data,
        output ser_ready, key_out, key_valid, busy, err
    );
endinterface

// File: rtl/cas_key_loader.sv
// Bit-serial key loader for the CAS-Lock c432 netlist: shifts in key + XOR checksum,
// verifies it, and commits the key write-once to a registered bus.
module cas_key_loader #(
    parameter int KEY_W = 64,
    parameter int CHK_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cas_key_loader_if.slave  bus
);
    localparam int TOTAL  = KEY_W + CHK_W;
    localparam int NSLICE = KEY_W / CHK_W;
    localparam int CNT_W  = $clog2(TOTAL);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        ARMED,
        ERROR
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [KEY_W-1:0] shadow_reg;
    logic [CHK_W-1:0] chk_reg;
    logic [KEY_W-1:0] key_reg;
    logic             ready_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             err_reg;

    logic             beat;
    logic [TOTAL-1:0] beat_hit;
    logic [KEY_W-1:0] shadow_next;
    logic [CHK_W-1:0] chk_next;
    logic [CHK_W-1:0] calc;

    assign beat = bus.ser_valid & ready_reg;

    // One-hot write enable per stream position, so each beat lands in exactly one bit.
    generate
        for (genvar gi = 0; gi < TOTAL; gi++) begin : g_beat_dec
            assign beat_hit[gi] = beat && (cnt_reg == CNT_W'(gi));
        end
    endgenerate

    assign shadow_next = (shadow_reg & ~beat_hit[KEY_W-1:0])
                       | ({KEY_W{bus.ser_data}} & beat_hit[KEY_W-1:0]);
    assign chk_next    = (chk_reg & ~beat_hit[TOTAL-1:KEY_W])
                       | ({CHK_W{bus.ser_data}} & beat_hit[TOTAL-1:KEY_W]);

    always_comb begin
        calc = '0;
        for (int j = 0; j < NSLICE; j++) begin
            calc = calc ^ shadow_reg[j*CHK_W +: CHK_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            shadow_reg <= '0;
            chk_reg    <= '0;
            key_reg    <= '0;
            ready_reg  <= 1'b0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else if (bus.clear) begin
            // Zeroise beats everything, including a final beat or load_start on this edge.
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            shadow_reg <= '0;
            chk_reg    <= '0;
            key_reg    <= '0;
            ready_reg  <= 1'b0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, ERROR: begin
                    if (bus.load_start) begin
                        state_reg  <= SHIFT;
                        cnt_reg    <= '0;
                        shadow_reg <= '0;
                        chk_reg    <= '0;
                        key_reg    <= '0;
                        valid_reg  <= 1'b0;
                        err_reg    <= 1'b0;
                        ready_reg  <= 1'b1;
                        busy_reg   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        shadow_reg <= shadow_next;
                        chk_reg    <= chk_next;
                        if (cnt_reg == LAST_BEAT) begin
                            state_reg <= CHECK;
                            ready_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    busy_reg <= 1'b0;
                    cnt_reg  <= '0;
                    if (calc == chk_reg) begin
                        state_reg <= ARMED;
                        key_reg   <= shadow_reg;
                        valid_reg <= 1'b1;
                    end else begin
                        state_reg  <= ERROR;
                        err_reg    <= 1'b1;
                        shadow_reg <= '0;
                    end
                end
                ARMED: begin
                    // Write-once: only clear or reset leave this state.
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ser_ready = ready_reg;
    assign bus.key_out   = key_reg;
    assign bus.key_valid = valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.err       = err_reg;
endmodule
